muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operation in flight; shift-add multiply and
// restoring divide run for Width cycles on unsigned magnitudes. Divide-by-zero and signed
// overflow complete through a single-cycle fast path. kill aborts the operation in flight.
module muldiv_unit #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             kill,
  output logic             valid_out,
  output logic [Width-1:0] result
);

  localparam int unsigned CntW = $clog2(Width + 1);
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q;
  logic [2:0]           op_q;
  logic                 sa_q, sb_q;
  logic [2*Width-1:0]   acc_q;    // multiply: product; divide: {remainder, quotient}
  logic [Width-1:0]     mcand_q;  // multiplicand or divisor magnitude
  logic [Width-1:0]     mplr_q;   // multiplier magnitude, consumed LSB first
  logic [CntW-1:0]      cnt_q;
  logic [Width-1:0]     stage_q;  // result of the operation now in DONE
  logic [Width-1:0]     res_q;    // last committed result

  logic                 a_signed, b_signed, a_neg, b_neg, fast;
  logic [Width-1:0]     a_mag, b_mag, fast_res;
  logic [Width:0]       mul_sum, rem_sh;
  logic [Width-1:0]     diff;
  logic                 ge;
  logic [2*Width-1:0]   step_acc, prod_fix;
  logic [Width-1:0]     quo_fix, rem_fix, fixed_res;

  // Operand preparation and fast-path detection on the request inputs
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && a[Width-1];
    b_neg    = b_signed && b[Width-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    fast     = 1'b0;
    fast_res = '0;
    if (op[2] && (b == '0)) begin
      fast     = 1'b1;
      fast_res = op[1] ? a : '1;
    end else if (op[2] && !op[0] && (a == MinVal) && (b == '1)) begin
      fast     = 1'b1;
      fast_res = op[1] ? '0 : a;
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus the final sign fix-up
  always_comb begin
    mul_sum = {1'b0, acc_q[2*Width-1:Width]} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
    rem_sh  = acc_q[2*Width-1:Width-1];
    ge      = rem_sh >= {1'b0, mcand_q};
    // Fits in Width bits whenever ge holds, since the remainder stays below the divisor
    diff    = rem_sh[Width-1:0] - mcand_q;
    if (op_q[2]) begin
      step_acc = {(ge ? diff : rem_sh[Width-1:0]), acc_q[Width-2:0], ge};
    end else begin
      step_acc = {mul_sum, acc_q[Width-1:1]};
    end
    prod_fix = (sa_q ^ sb_q) ? (~step_acc + 1'b1) : step_acc;
    quo_fix  = (sa_q ^ sb_q) ? (~step_acc[Width-1:0] + 1'b1) : step_acc[Width-1:0];
    rem_fix  = sa_q ? (~step_acc[2*Width-1:Width] + 1'b1) : step_acc[2*Width-1:Width];
    if (op_q[2]) begin
      fixed_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      fixed_res = (op_q[1:0] == 2'b00) ? prod_fix[Width-1:0] : prod_fix[2*Width-1:Width];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_in && !kill) begin
            op_q    <= op;
            sa_q    <= a_neg;
            sb_q    <= b_neg;
            mcand_q <= op[2] ? b_mag : a_mag;
            mplr_q  <= b_mag;
            acc_q   <= op[2] ? {{Width{1'b0}}, a_mag} : '0;
            if (fast) begin
              stage_q <= fast_res;
              state_q <= StDone;
            end else begin
              cnt_q   <= CntW'(Width);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (kill) begin
            state_q <= StIdle;
          end else begin
            acc_q  <= step_acc;
            mplr_q <= mplr_q >> 1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
              stage_q <= fixed_res;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (!kill) res_q <= stage_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A kill during DONE hides the pending result: the old committed value stays visible
  assign ready_out = (state_q == StIdle);
  assign valid_out = (state_q == StDone) && !kill;
  assign result    = valid_out ? stage_q : res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a cycle-level reference model and per-cycle monitor.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          ready_out;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          kill;
  logic          valid_out;
  logic [W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  muldiv_unit #(.Width(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out), .op(op),
    .a(a), .b(b), .kill(kill), .valid_out(valid_out), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Architectural RV32M result computed with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, ux, uy, q;
    logic [63:0] p;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        q = sx / sy; return q[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        q = ux / uy; return q[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        q = sx % sy; return q[31:0];
      end
      default: begin
        if (y == 0) return x;
        q = ux % uy; return q[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Model timeline: m_cyc is the cycle number since the accept edge
  bit          m_busy = 1'b0;
  int          m_cyc  = 0;
  int          m_lat  = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_last = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = '0;
    end else if (m_busy) begin
      if (m_cyc == m_lat) begin
        if (!kill) m_last = m_pend;
        m_busy = 1'b0;
      end else if (kill) begin
        m_busy = 1'b0;
      end else begin
        m_cyc++;
      end
    end else if (valid_in && !kill) begin
      m_busy = 1'b1;
      m_cyc  = 1;
      m_lat  = is_fast(op, a, b) ? 1 : W + 1;
      m_pend = ref_model(op, a, b);
    end
  end

  // Compare DUT against the model on every falling edge
  initial forever begin
    logic ev;
    @(negedge clk);
    if (mon_en && rst_n) begin
      ev = m_busy && (m_cyc == m_lat) && !kill;
      check("mon ready_out", 32'(ready_out), 32'(!m_busy));
      check("mon valid_out", 32'(valid_out), 32'(ev));
      check("mon result", result, ev ? m_pend : m_last);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready_out && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!ready_out) timeout_fail("wait ready_out");
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_cyc);
    int c;
    bit seen;
    check({name, " model"}, ref_model(o, x, y), exp);
    wait_ready();
    op = o; a = x; b = y; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    a = ~x; b = ~y;
    c = 1; seen = 1'b0;
    while (!seen && c <= 100) begin
      if (valid_out) begin
        seen = 1'b1;
        check(name, result, exp);
        check({name, " cycle"}, 32'(c), 32'(exp_cyc));
      end else begin
        @(posedge clk); #1; c++;
      end
    end
    if (!seen) timeout_fail(name);
    @(posedge clk); #1;
    check({name, " ready after"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready_out", 32'(ready_out), 32'd1);
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("MULH -3*5", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 33);
    run_op("MULHSU min*2", 3'd2, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIV 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("REM 7/-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("DIVU max/1", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("REM -7/-2", 3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);

    // Kill in cycle 10 of a DIV
    wait_ready();
    op = 3'd4; a = 32'd100; b = 32'd7; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check("kill div no valid", 32'(valid_out), 32'd0);
      if (c == 10) kill = 1'b1;
      @(posedge clk); #1;
    end
    kill = 1'b0;
    check("kill div ready c11", 32'(ready_out), 32'd1);
    check("kill div result kept", result, 32'hFFFF_FFFF);
    run_op("MUL 3*4 after kill", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Kill during the DONE cycle of a fast-path op
    op = 3'd5; a = 32'd5; b = 32'd0; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; kill = 1'b1;
    #1;
    check("kill done valid", 32'(valid_out), 32'd0);
    check("kill done result", result, 32'd12);
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill done ready", 32'(ready_out), 32'd1);
    check("kill done result after", result, 32'd12);

    // Asynchronous reset in cycle 5 of a MUL
    op = 3'd0; a = 32'd9; b = 32'd9; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async rst ready_out", 32'(ready_out), 32'd1);
    check("async rst valid_out", 32'(valid_out), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // valid_in held high; operands churn during CALC
    op = 3'd0; a = 32'd5; b = 32'd6; valid_in = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      @(posedge clk); #1;
      if (c == 33) begin
        check("hs first valid", 32'(valid_out), 32'd1);
        check("hs first result", result, 32'd30);
        a = 32'd2; b = 32'd9;
      end else if (c == 34) begin
        check("hs ready c34", 32'(ready_out), 32'd1);
      end else if (c == 67) begin
        check("hs second valid", 32'(valid_out), 32'd1);
        check("hs second result", result, 32'd18);
        valid_in = 1'b0;
      end else if (c < 33) begin
        a = $urandom; b = $urandom;
      end
    end
    @(posedge clk); #1;

    // valid_in with kill in IDLE must not be accepted
    op = 3'd0; a = 32'd1; b = 32'd1; valid_in = 1'b1; kill = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle kill ready", 32'(ready_out), 32'd1);
      check("idle kill valid", 32'(valid_out), 32'd0);
    end
    valid_in = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
